// File: rtl/lcd_init_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg -- shared definitions for the LCD init sequencer.
//   op_e     : op codes held in ROM word bits [15:14]
//   state_e  : sequencer FSM state encoding
//   field positions of the 16-bit init word and the ms count width
// No ports.
// ---------------------------------------------------------------------------
package lcd_pkg;

  typedef enum logic [1:0] {
    OP_CMD   = 2'b00,
    OP_DATA  = 2'b01,
    OP_DELAY = 2'b10,
    OP_END   = 2'b11
  } op_e;

  // Init word layout: [15:14] op, [13:0] delay ms, [7:0] byte payload.
  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 14;
  localparam int DLY_MSB  = 13;
  localparam int BYTE_MSB = 7;

  // Width of the millisecond count (matches the delay field).
  localparam int MS_W = DLY_MSB + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HW_RST,
    S_HW_WAIT,
    S_FETCH,
    S_ISSUE,
    S_DLY,
    S_DONE
  } state_e;

endpackage

// File: rtl/lcd_init_sequencer_if.sv
// ---------------------------------------------------------------------------
// lcd_init_sequencer_if -- byte stream from the init sequencer to the LCD
// byte writer (SPI/8080).
//   wr_valid : byte available            (master -> slave)
//   wr_dc    : 0 = command, 1 = data      (master -> slave)
//   wr_byte  : byte payload               (master -> slave)
//   wr_ready : writer accepts the byte    (slave  -> master)
// A byte transfers on a cycle with wr_valid & wr_ready.
// ---------------------------------------------------------------------------
interface lcd_init_sequencer_if;

  logic       wr_valid;
  logic       wr_dc;
  logic [7:0] wr_byte;
  logic       wr_ready;

  modport master (output wr_valid, output wr_dc, output wr_byte, input wr_ready);
  modport slave  (input wr_valid, input wr_dc, input wr_byte, output wr_ready);

endinterface

// File: rtl/lcd_delay_timer.sv
// ---------------------------------------------------------------------------
// lcd_delay_timer -- millisecond delay shared by the panel reset phases and
// the ROM DELAY words.
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   go   : load ms and start counting (restarts a running count)
//   ms   : delay in ms, sampled with go; 0 loads nothing and never fires
//   done : one-cycle pulse in the last of ms*CLK_PER_MS cycles after go
// ---------------------------------------------------------------------------
module lcd_delay_timer
  import lcd_pkg::*;
#(
  parameter int CLK_PER_MS = 50000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go,
  input  logic [MS_W-1:0] ms,
  output logic            done
);

  localparam int            PW       = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0] PRE_LOAD = PW'(CLK_PER_MS - 1);

  logic [PW-1:0]   pre_q, pre_d;
  logic [MS_W-1:0] ms_q, ms_d;
  logic            run_q, run_d;

  // Last prescaler tick of the last millisecond.
  assign done = run_q && (pre_q == '0) && (ms_q == MS_W'(1));

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    pre_d = pre_q;
    ms_d  = ms_q;
    run_d = run_q;
    if (go) begin
      run_d = (ms != '0);
      pre_d = PRE_LOAD;
      ms_d  = ms;
    end else if (run_q) begin
      if (pre_q != '0) begin
        pre_d = pre_q - 1'b1;
      end else if (ms_q == MS_W'(1)) begin
        run_d = 1'b0;                 // done cycle; counters park, never wrap
      end else begin
        pre_d = PRE_LOAD;
        ms_d  = ms_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (rst) begin
      pre_q <= '0;
      ms_q  <= '0;
      run_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      ms_q  <= ms_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/lcd_init_sequencer.sv
// ---------------------------------------------------------------------------
// lcd_init_sequencer -- walks the LCD init ROM from address 0, pulses the
// panel hardware reset, then streams command/data bytes to the byte writer,
// honouring DELAY words, until an END word (or ROM overrun).
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin init; only honoured in IDLE or DONE
//   rom_addr   : registered ROM address
//   rom_data   : ROM word at rom_addr, same cycle
//   wr         : byte stream to the writer (master side)
//   lcd_rst_n  : panel reset, low only while in HW_RST
//   busy       : high outside IDLE and DONE
//   init_done  : high in DONE
//   init_err   : ROM ran out without an END word
// ---------------------------------------------------------------------------
module lcd_init_sequencer
  import lcd_pkg::*;
#(
  parameter int ADDR_WIDTH  = 7,
  parameter int DATA_WIDTH  = 16,
  parameter int CLK_PER_MS  = 50000,
  parameter int RST_LOW_MS  = 10,
  parameter int RST_HIGH_MS = 120
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  lcd_init_sequencer_if.master  wr,
  output logic                  lcd_rst_n,
  output logic                  busy,
  output logic                  init_done,
  output logic                  init_err
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  valid_q, valid_d;
  logic                  dc_q, dc_d;
  logic [7:0]            byte_q, byte_d;
  logic                  err_q, err_d;

  op_e             op;
  logic            step;     // current word finished: advance or stop at the top
  logic            tmr_go;
  logic [MS_W-1:0] tmr_ms;
  logic            tmr_done;

  lcd_delay_timer #(.CLK_PER_MS(CLK_PER_MS)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .go   (tmr_go),
    .ms   (tmr_ms),
    .done (tmr_done)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    dc_d    = dc_q;
    byte_d  = byte_q;
    err_d   = err_q;
    tmr_go  = 1'b0;
    tmr_ms  = '0;
    step    = 1'b0;
    op      = op_e'(rom_data[OP_MSB:OP_LSB]);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_HW_RST;
          addr_d  = '0;
          err_d   = 1'b0;
          tmr_go  = 1'b1;
          tmr_ms  = MS_W'(RST_LOW_MS);
        end
      end
      S_HW_RST: begin
        if (tmr_done) begin
          state_d = S_HW_WAIT;
          tmr_go  = 1'b1;
          tmr_ms  = MS_W'(RST_HIGH_MS);
        end
      end
      S_HW_WAIT: begin
        if (tmr_done) state_d = S_FETCH;
      end
      S_FETCH: begin
        case (op)
          OP_CMD, OP_DATA: begin
            state_d = S_ISSUE;
            valid_d = 1'b1;
            dc_d    = (op == OP_DATA);
            byte_d  = rom_data[BYTE_MSB:0];
          end
          OP_DELAY: begin
            // A zero delay skips DLY entirely: next fetch in the next cycle.
            if (rom_data[DLY_MSB:0] == '0) begin
              step = 1'b1;
            end else begin
              state_d = S_DLY;
              tmr_go  = 1'b1;
              tmr_ms  = rom_data[DLY_MSB:0];
            end
          end
          default: state_d = S_DONE;  // OP_END
        endcase
      end
      S_ISSUE: begin
        if (wr.wr_ready) begin
          valid_d = 1'b0;
          step    = 1'b1;
        end
      end
      S_DLY: begin
        if (tmr_done) step = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // The last ROM word is processed normally; running past it is an error,
    // and the address parks there instead of wrapping.
    if (step) begin
      if (addr_q == ADDR_MAX) begin
        state_d = S_DONE;
        err_d   = 1'b1;
      end else begin
        addr_d  = addr_q + 1'b1;
        state_d = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      valid_q <= 1'b0;
      dc_q    <= 1'b0;
      byte_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      dc_q    <= dc_d;
      byte_q  <= byte_d;
      err_q   <= err_d;
    end
  end

  assign rom_addr    = addr_q;
  assign wr.wr_valid = valid_q;
  assign wr.wr_dc    = dc_q;
  assign wr.wr_byte  = byte_q;
  assign lcd_rst_n   = (state_q != S_HW_RST);
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign init_done   = (state_q == S_DONE);
  assign init_err    = err_q;

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lcd_init_sequencer -- self-checking bench for lcd_init_sequencer with a
// behavioural ROM. The reference model walks the ROM array and lists the
// (dc, byte) pairs the writer must receive, plus the final error flag and
// address; a monitor logs every transfer and checks stall stability.
// ---------------------------------------------------------------------------
module tb_lcd_init_sequencer;

  localparam int CLK_PER_MS  = 4;
  localparam int RST_LOW_MS  = 1;
  localparam int RST_HIGH_MS = 2;
  localparam int AW          = 7;
  localparam int DEPTH       = 1 << AW;
  localparam int HW_CYC      = (RST_LOW_MS + RST_HIGH_MS) * CLK_PER_MS;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          start = 1'b0;
  logic          rdy   = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data;
  logic          lcd_rst_n, busy, init_done, init_err;

  logic [15:0] rom [DEPTH];

  int   vectors     = 0;
  int   miscompares = 0;
  int   rdy_mode    = 0;   // 0: always ready, 1: random, 2: 5-cycle stall per byte
  int   stall       = 0;
  int   stall_seen  = 0;
  int   cyc         = 0;
  time  start_t;

  bit [8:0] got_q[$];
  bit [8:0] exp_q[$];
  int       rise_q[$];
  int       acc_q[$];
  bit       exp_err;
  int       exp_addr;

  bit        hold_pend  = 1'b0;
  bit        prev_valid = 1'b0;
  logic [9:0] held;

  lcd_init_sequencer_if tb_if ();

  lcd_init_sequencer #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (16),
    .CLK_PER_MS  (CLK_PER_MS),
    .RST_LOW_MS  (RST_LOW_MS),
    .RST_HIGH_MS (RST_HIGH_MS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .wr        (tb_if),
    .lcd_rst_n (lcd_rst_n),
    .busy      (busy),
    .init_done (init_done),
    .init_err  (init_err)
  );

  assign rom_data       = rom[rom_addr];
  assign tb_if.wr_ready = rdy;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Writer-side ready pattern, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: rdy = 1'b1;
      1: rdy = 1'($urandom_range(0, 1));
      default: begin
        if (tb_if.wr_valid && stall < 5) begin
          rdy = 1'b0;
          stall++;
        end else begin
          rdy = tb_if.wr_valid;
          if (!tb_if.wr_valid) stall = 0;
        end
      end
    endcase
  end

  // Transfer log and stall-stability check, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (!rst && hold_pend)
      check("hold_stable", 32'({tb_if.wr_valid, tb_if.wr_dc, tb_if.wr_byte}), 32'(held));
    hold_pend = !rst && tb_if.wr_valid && !tb_if.wr_ready;
    held      = {1'b1, tb_if.wr_dc, tb_if.wr_byte};
    if (hold_pend) stall_seen++;
    if (!rst && tb_if.wr_valid && !prev_valid) rise_q.push_back(cyc);
    prev_valid = tb_if.wr_valid;
    if (!rst && tb_if.wr_valid && tb_if.wr_ready) begin
      got_q.push_back({tb_if.wr_dc, tb_if.wr_byte});
      acc_q.push_back(cyc);
    end
  end

  // Reference: bytes in ROM order up to END; no END means error at the top address.
  function automatic void build_model();
    exp_q.delete();
    exp_err  = 1'b1;
    exp_addr = DEPTH - 1;
    for (int a = 0; a < DEPTH; a++) begin
      if (rom[a][15:14] == 2'b11) begin
        exp_err  = 1'b0;
        exp_addr = a;
        break;
      end
      if (rom[a][15] == 1'b0) exp_q.push_back({rom[a][14], rom[a][7:0]});
    end
  endfunction

  task automatic fill_rom();
    for (int i = 0; i < DEPTH; i++) rom[i] = 16'($urandom);
  endtask

  task automatic check_idle(input string tag);
    check(tag, 32'({rom_addr, tb_if.wr_valid, tb_if.wr_dc, tb_if.wr_byte,
                    lcd_rst_n, busy, init_done, init_err}),
               32'({7'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0}));
  endtask

  // Pulse start, check the first cycle after it, and measure both reset phases.
  // exp_wait < 0 skips the wait-to-first-byte check.
  task automatic start_seq(input string tag, input int exp_wait);
    int low = 0;
    int hi  = 0;
    got_q.delete();
    acc_q.delete();
    rise_q.delete();
    stall_seen = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    start_t = $time;
    check({tag, "_n1"}, 32'({lcd_rst_n, busy, rom_addr, init_done, init_err}),
                        32'({1'b0, 1'b1, 7'd0, 1'b0, 1'b0}));
    while (!lcd_rst_n && low < 1000) begin low++; @(negedge clk); end
    check({tag, "_rst_low"}, 32'(low), 32'(RST_LOW_MS * CLK_PER_MS));
    while (!tb_if.wr_valid && !init_done && hi < 1000) begin hi++; @(negedge clk); end
    if (exp_wait >= 0) check({tag, "_wait"}, 32'(hi), 32'(exp_wait));
  endtask

  // Wait for init_done; optionally pulse start once while still busy.
  task automatic wait_done(input string tag, input int poke_at, output int dur);
    int  n  = 0;
    bit  ok = 1'b0;
    dur = -1;
    while (n < 4000) begin
      @(negedge clk);
      n++;
      if (init_done) begin ok = 1'b1; break; end
      if (n == poke_at) begin
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
    end
    if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
    else dur = int'(($time - start_t) / 10);
  endtask

  task automatic compare_run(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, "_end"}, 32'({init_done, busy, init_err, rom_addr}),
                         32'({1'b1, 1'b0, exp_err, 7'(exp_addr)}));
  endtask

  initial begin
    int dur, dur_a, g1, g2, len;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); check_idle("reset");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); check_idle("idle");

    // 1: basic CMD/DATA; a CMD first word adds one FETCH cycle before valid
    fill_rom();
    rom[0] = 16'h0011; rom[1] = 16'h4055; rom[2] = 16'hC000;
    build_model();
    check("t1_model", 32'({exp_q[0], exp_q[1]}), 32'({9'h011, 9'h155}));
    rdy_mode = 0;
    start_seq("t1", RST_HIGH_MS * CLK_PER_MS + 1);
    wait_done("t1", 0, dur);
    compare_run("t1");
    check("t1_cycles", 32'(dur), 32'(HW_CYC + 2 + 2 + 1));

    // 2: DELAY 3 ms versus DELAY 0
    fill_rom();
    rom[0] = 16'h002A; rom[1] = 16'h8003; rom[2] = 16'h0029;
    rom[3] = 16'h8000; rom[4] = 16'h0030; rom[5] = 16'hC000;
    build_model();
    start_seq("t2", RST_HIGH_MS * CLK_PER_MS + 1);
    wait_done("t2", 0, dur);
    compare_run("t2");
    if (acc_q.size() >= 3 && rise_q.size() >= 3) begin
      g1 = rise_q[1] - acc_q[0];
      g2 = rise_q[2] - acc_q[1];
      // zero delay: FETCH of delay word, FETCH of next word, then valid
      check("t2_zero_delay_gap", 32'(g2), 32'd3);
      check("t2_delay_added", 32'((g1 - g2 >= 3 * CLK_PER_MS - 1) && (g1 - g2 <= 3 * CLK_PER_MS + 1)), 32'd1);
    end else begin
      check("t2_gap_samples", 32'(acc_q.size()), 32'd3);
    end

    // 3: 5-cycle stall per byte, ignored bits [13:8] set
    fill_rom();
    rom[0] = 16'h0012; rom[1] = 16'h7F34; rom[2] = 16'h3F56; rom[3] = 16'h4078; rom[4] = 16'hC000;
    build_model();
    rdy_mode = 2;
    start_seq("t3", -1);
    wait_done("t3", 0, dur);
    compare_run("t3");
    check("t3_stall_cycles", 32'(stall_seen), 32'(5 * exp_q.size()));

    // 4: no END word -> overrun
    for (int i = 0; i < DEPTH; i++) rom[i] = 16'h0000;
    build_model();
    rdy_mode = 0;
    start_seq("t4", RST_HIGH_MS * CLK_PER_MS + 1);
    wait_done("t4", 0, dur);
    compare_run("t4");
    check("t4_cycles", 32'(dur), 32'(HW_CYC + 2 * DEPTH));
    repeat (5) @(negedge clk);
    check("t4_parked", 32'({rom_addr, init_done, init_err}), 32'({7'd127, 1'b1, 1'b1}));

    // 6: restart from DONE (clears init_err at N+1), then start pokes while busy
    fill_rom();
    rom[0] = 16'h0011; rom[1] = 16'h8002; rom[2] = 16'h4022; rom[3] = 16'hC000;
    build_model();
    start_seq("t6a", RST_HIGH_MS * CLK_PER_MS + 1);
    wait_done("t6a", 0, dur_a);
    compare_run("t6a");
    start_seq("t6b", RST_HIGH_MS * CLK_PER_MS + 1);
    wait_done("t6b", 3, dur);
    compare_run("t6b");
    check("t6_same_timing", 32'(dur), 32'(dur_a));

    // 5a: rst in the middle of a delay
    fill_rom();
    rom[0] = 16'h0011; rom[1] = 16'h8005; rom[2] = 16'h4022; rom[3] = 16'hC000;
    build_model();
    start_seq("t5a", RST_HIGH_MS * CLK_PER_MS + 1);
    for (int i = 0; i < 100 && acc_q.size() == 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk); check_idle("t5a_rst");
    check("t5a_partial", 32'(got_q.size()), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    start_seq("t5a_re", RST_HIGH_MS * CLK_PER_MS + 1);
    wait_done("t5a_re", 0, dur);
    compare_run("t5a_re");

    // 5b: rst while a byte is stalled in ISSUE; the byte never transfers
    rdy_mode = 2;
    start_seq("t5b", RST_HIGH_MS * CLK_PER_MS + 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk); check_idle("t5b_rst");
    check("t5b_no_xfer", 32'(got_q.size()), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    rdy_mode = 0;
    start_seq("t5b_re", RST_HIGH_MS * CLK_PER_MS + 1);
    wait_done("t5b_re", 0, dur);
    compare_run("t5b_re");

    // Random ROM programs with random writer backpressure
    for (int k = 0; k < 6; k++) begin
      fill_rom();
      len = $urandom_range(3, 24);
      for (int a = 0; a < len - 1; a++) begin
        case ($urandom_range(0, 3))
          0:       rom[a] = {2'b00, 6'($urandom), 8'($urandom)};
          1:       rom[a] = {2'b01, 6'($urandom), 8'($urandom)};
          2:       rom[a] = {2'b10, 14'($urandom_range(0, 2))};
          default: rom[a] = {1'b0, 1'($urandom), 6'($urandom), 8'($urandom)};
        endcase
      end
      rom[len - 1] = {2'b11, 14'($urandom)};
      build_model();
      rdy_mode = 1;
      start_seq($sformatf("rnd%0d", k), -1);
      wait_done($sformatf("rnd%0d", k), 0, dur);
      compare_run($sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running, required finished");
    $fatal(1, "watchdog");
  end

endmodule
